// File: rtl/spi_master_arbiter.sv
// Two-requester round-robin front end for a single SPI master driver.
// All outputs are registered; each pulse appears the cycle after the FSM step that produces it.
module spi_master_arbiter #(
    parameter int START_TIMEOUT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_bi,
    input  logic [7:0] tx0_bi,
    input  logic [7:0] tx1_bi,
    output logic [1:0] ack_bo,
    output logic [1:0] done_bo,
    output logic [7:0] rx_data_bo,
    output logic       err_o,
    output logic       start_o,
    output logic [7:0] data_bo,
    input  logic       busy_i,
    input  logic [7:0] data_bi
);

    localparam int CW = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, XFER, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      ack_q, ack_d, done_q, done_d;
    logic            err_q, err_d, start_q, start_d;
    logic [7:0]      data_q, data_d, rx_q, rx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d, gnt_q, gnt_d, tmo_q, tmo_d;
    logic            nxt_gnt;

    // Contention goes to whoever did not win last; a lone requester always wins.
    assign nxt_gnt = (req_bi == 2'b11) ? ~last_q : req_bi[1];

    always_comb begin
        state_d = state_q;
        ack_d   = 2'b00;
        done_d  = 2'b00;
        err_d   = 1'b0;
        start_d = 1'b0;
        data_d  = data_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (req_bi != 2'b00) begin
                    gnt_d   = nxt_gnt;
                    data_d  = nxt_gnt ? tx1_bi : tx0_bi;
                    ack_d   = nxt_gnt ? 2'b10 : 2'b01;
                    tmo_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_i) begin
                    state_d = XFER;
                end else if (cnt_q == CW'(START_TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            XFER: begin
                if (!busy_i) begin
                    rx_d    = data_bi;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = gnt_q ? 2'b10 : 2'b01;
                err_d   = tmo_q;
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ack_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            rx_q    <= 8'h00;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            data_q  <= data_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign ack_bo     = ack_q;
    assign done_bo    = done_q;
    assign err_o      = err_q;
    assign start_o    = start_q;
    assign data_bo    = data_q;
    assign rx_data_bo = rx_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed vector bench for spi_master_arbiter with a small behavioural SPI driver model.
module tb_spi_master_arbiter;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic [1:0] req_bi = 2'b00;
    logic [7:0] tx0_bi = 8'h00, tx1_bi = 8'h00;
    logic [1:0] ack_bo, done_bo;
    logic [7:0] rx_data_bo, data_bo;
    logic       err_o, start_o;
    logic       busy_i;
    logic [7:0] data_bi;

    logic       slv_en = 1'b1;
    logic [7:0] slv_byte = 8'h00;
    int         scnt;
    int         checks = 0;
    int         failures = 0;

    spi_master_arbiter #(.START_TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_bi(req_bi), .tx0_bi(tx0_bi), .tx1_bi(tx1_bi),
        .ack_bo(ack_bo), .done_bo(done_bo), .rx_data_bo(rx_data_bo), .err_o(err_o),
        .start_o(start_o), .data_bo(data_bo), .busy_i(busy_i), .data_bi(data_bi)
    );

    always #5 clk = ~clk;

    // Driver model: busy rises the edge after start is seen, stays up 3 cycles, then presents the byte.
    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            busy_i  <= 1'b0;
            scnt    <= 0;
            data_bi <= 8'h00;
        end else if (start_o && slv_en) begin
            busy_i <= 1'b1;
            scnt   <= 3;
        end else if (scnt != 0) begin
            scnt <= scnt - 1;
            if (scnt == 1) begin
                busy_i  <= 1'b0;
                data_bi <= slv_byte;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_i) begin
            chk("onehot_ack", 32'($countones(ack_bo) <= 1), 32'd1);
            if (ack_bo != 2'b00 && done_bo != 2'b00)
                chk("ack_done_overlap", {30'd0, done_bo}, 32'd0);
        end
    end

    typedef struct {
        bit         rst;
        logic [1:0] req, req_after;
        logic [7:0] tx0, tx1, slv;
        bit         slv_en;
        logic [1:0] exp_ack;
        logic [7:0] exp_data, exp_rx;
        bit         exp_err;
    } vec_t;

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    task automatic do_xfer(input vec_t v);
        int cyc;
        bit seen;
        if (v.rst) do_reset();
        req_bi   = v.req;
        tx0_bi   = v.tx0;
        tx1_bi   = v.tx1;
        slv_byte = v.slv;
        slv_en   = v.slv_en;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ack_bo != 2'b00) seen = 1'b1;
        end
        chk("ack_seen", {31'd0, seen}, 32'd1);
        chk("ack_bo", {30'd0, ack_bo}, {30'd0, v.exp_ack});
        chk("data_bo_latch", {24'd0, data_bo}, {24'd0, v.exp_data});
        req_bi = v.req_after;
        @(negedge clk);
        chk("start_pulse", {31'd0, start_o}, 32'd1);
        tx0_bi = ~v.tx0;
        tx1_bi = ~v.tx1;
        cyc = 0;
        @(negedge clk);
        cyc++;
        chk("start_single", {31'd0, start_o}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done_bo != 2'b00) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("done_bo", {30'd0, done_bo}, {30'd0, v.exp_ack});
        chk("err_o", {31'd0, err_o}, {31'd0, v.exp_err});
        chk("rx_data_bo", {24'd0, rx_data_bo}, {24'd0, v.exp_rx});
        chk("data_bo_hold", {24'd0, data_bo}, {24'd0, v.exp_data});
        if (v.exp_err) chk("timeout_latency", 32'(cyc), 32'(TO + 2));
    endtask

    vec_t vecs[8];
    vec_t post;

    initial begin
        //          rst   req    after  tx0    tx1    slv    en    ack    data   rx     err
        vecs[0] = '{1'b1, 2'b01, 2'b00, 8'h35, 8'h00, 8'hA3, 1'b1, 2'b01, 8'h35, 8'hA3, 1'b0};
        vecs[1] = '{1'b1, 2'b11, 2'b11, 8'h11, 8'h22, 8'h5C, 1'b1, 2'b01, 8'h11, 8'h5C, 1'b0};
        vecs[2] = '{1'b0, 2'b11, 2'b11, 8'h11, 8'h22, 8'h6D, 1'b1, 2'b10, 8'h22, 8'h6D, 1'b0};
        vecs[3] = '{1'b0, 2'b11, 2'b11, 8'h11, 8'h22, 8'h7E, 1'b1, 2'b01, 8'h11, 8'h7E, 1'b0};
        vecs[4] = '{1'b0, 2'b11, 2'b00, 8'h11, 8'h22, 8'h8F, 1'b1, 2'b10, 8'h22, 8'h8F, 1'b0};
        vecs[5] = '{1'b0, 2'b10, 2'b00, 8'h00, 8'hC4, 8'hEE, 1'b0, 2'b10, 8'hC4, 8'h8F, 1'b1};
        vecs[6] = '{1'b0, 2'b01, 2'b00, 8'h5A, 8'h00, 8'h3B, 1'b1, 2'b01, 8'h5A, 8'h3B, 1'b0};
        vecs[7] = '{1'b0, 2'b10, 2'b00, 8'h00, 8'h99, 8'h42, 1'b1, 2'b10, 8'h99, 8'h42, 1'b0};
        post    = '{1'b0, 2'b01, 2'b00, 8'h44, 8'h00, 8'h19, 1'b1, 2'b01, 8'h44, 8'h19, 1'b0};

        #1;
        chk("rst_start", {31'd0, start_o}, 32'd0);
        chk("rst_ack", {30'd0, ack_bo}, 32'd0);
        chk("rst_done", {30'd0, done_bo}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_data", {24'd0, data_bo}, 32'd0);
        chk("rst_rx", {24'd0, rx_data_bo}, 32'd0);
        @(negedge clk);
        rst_i = 1'b1;

        for (int i = 0; i < 8; i++) do_xfer(vecs[i]);

        // Reset asserted while the driver is busy must abort silently.
        begin
            bit seen;
            req_bi = 2'b01;
            tx0_bi = 8'h77;
            slv_en = 1'b1;
            slv_byte = 8'hD1;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (ack_bo != 2'b00) seen = 1'b1;
            end
            chk("mid_ack_seen", {31'd0, seen}, 32'd1);
            req_bi = 2'b00;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (busy_i) seen = 1'b1;
            end
            chk("mid_busy_seen", {31'd0, seen}, 32'd1);
            rst_i = 1'b0;
            #1;
            chk("mid_rst_start", {31'd0, start_o}, 32'd0);
            chk("mid_rst_done", {30'd0, done_bo}, 32'd0);
            chk("mid_rst_data", {24'd0, data_bo}, 32'd0);
            chk("mid_rst_rx", {24'd0, rx_data_bo}, 32'd0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("mid_rst_hold_done", {30'd0, done_bo}, 32'd0);
            end
            rst_i = 1'b1;
            @(negedge clk);
            chk("post_rst_idle_done", {30'd0, done_bo}, 32'd0);
            do_xfer(post);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master_arbiter.md
SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 SHALL have parameter START_TIMEOUT, default 4, max cycles to wait for busy_i to rise after start_o.
REQ-002 SHALL have port clk_i  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_bi  input  2  per-requester transfer request, level.
REQ-005 SHALL have port tx0_bi  input  8  requester 0 transmit byte.
REQ-006 SHALL have port tx1_bi  input  8  requester 1 transmit byte.
REQ-007 SHALL have port ack_bo  output  2  one-hot pulse: request accepted, tx byte latched.
REQ-008 SHALL have port done_bo  output  2  one-hot pulse: transfer complete, rx_data_bo valid.
REQ-009 SHALL have port rx_data_bo  output  8  received byte of last completed transfer.
REQ-010 SHALL have port err_o  output  1  pulse with done_bo: busy_i never rose (timeout).
REQ-011 SHALL have port start_o  output  1  to spi_master_driver start_i.
REQ-012 SHALL have port data_bo  output  8  to spi_master_driver data_in_bi.
REQ-013 SHALL have port busy_i  input  1  from spi_master_driver busy_o.
REQ-014 SHALL have port data_bi  input  8  from spi_master_driver data_out_bo.

Function
REQ-015 SHALL implement FSM states IDLE, START, WAIT_BUSY, XFER, DONE.
REQ-016 IDLE: if req_bi != 0, SHALL select grant g, latch tx_g into data_bo, pulse ack_bo[g] that cycle, go START; else stay.
REQ-017 Arbitration SHALL be round-robin over a 1-bit last_grant: both requesting -> grant the one != last_grant; single requester -> grant it.
REQ-018 START: start_o SHALL be 1 for exactly this one cycle; clear timeout counter; go WAIT_BUSY.
REQ-019 WAIT_BUSY: busy_i=1 -> XFER; else increment counter; counter reaching START_TIMEOUT -> DONE with timeout flag set.
REQ-020 XFER: busy_i=0 -> capture data_bi into rx_data_bo, go DONE; else stay (no timeout in XFER).
REQ-021 DONE: pulse done_bo[g] one cycle; err_o=1 same cycle iff timeout flag; last_grant<=g; go IDLE.
REQ-022 On timeout rx_data_bo SHALL retain its previous value.
REQ-023 data_bo SHALL stay constant from latch in IDLE until next grant; tx inputs ignored outside IDLE.
REQ-024 Latency: acceptance cycle n -> start_o at n+1; done_bo one cycle after busy_i observed low in XFER.
REQ-025 req_bi changes outside IDLE SHALL be ignored; a req still high in IDLE after DONE SHALL be a new request (requester drops req after ack).
REQ-026 Minimum spacing: one IDLE cycle between DONE and next START.
REQ-027 ack_bo, done_bo SHALL be one-hot or zero; never both bits set.

Reset
REQ-028 rst_i low SHALL immediately force: state IDLE, start_o=0, ack_bo=0, done_bo=0, err_o=0, data_bo=0, rx_data_bo=0, counter=0, last_grant=1 (requester 0 wins first contest).
REQ-029 Reset mid-transfer SHALL abort without done_bo pulse; first post-reset request handled from IDLE.

Verification
REQ-030 Single request: req_bi=01, tx0=0x35, slave byte 0xA3 -> ack_bo=01, one-cycle start_o next cycle, data_bo=0x35, later done_bo=01, rx_data_bo=0xA3, err_o=0.
REQ-031 Contention: req_bi=11 held, tx0=0x11, tx1=0x22 after reset -> grants order 0,1,0,1; data_bo 0x11,0x22 alternating; ack/done one-hot.
REQ-032 Timeout: busy_i tied 0, req_bi=10 -> start_o pulse, done_bo=10 with err_o=1 exactly START_TIMEOUT+2 cycles after start_o, rx_data_bo unchanged.
REQ-033 Mid-transfer reset: rst_i low during XFER -> start_o/done_bo stay 0, state IDLE; next req_bi=01 gets ack_bo=01 (last_grant=1).
REQ-034 Input stability: change tx0_bi and drop req_bi during XFER -> data_bo unchanged, transfer completes with done_bo=01.
